// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the dual-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned AW_DEF   = 14;
  localparam int unsigned NREQ_DEF = 3;
  localparam int unsigned DW       = 32;
  localparam int unsigned BW       = 4;

  // Requester index that port B's round-robin pointer holds out of reset.
  localparam int unsigned RR_PTR_RST = NREQ_DEF - 1;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic              wren;
    logic [DW-1:0]     wdata;
    logic [BW-1:0]     bmask;
  } sram_req_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rdata;
  } sram_rsp_t;

  // Reset pointer for an n-slot arbiter: the last slot, so slot 0 is searched first.
  function automatic int unsigned rr_ptr_rst(input int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester handshake and SRAM macro pins for sram_port_arbiter.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned AW   = AW_DEF
);

  logic [NREQ-1:0]          i_req_valid;
  logic [NREQ-1:0][AW-1:0]  i_req_addr;
  logic [NREQ-1:0]          i_req_wren;
  logic [NREQ-1:0][DW-1:0]  i_req_wdata;
  logic [NREQ-1:0][BW-1:0]  i_req_bmask;
  logic [NREQ-1:0]          o_req_ready;
  logic [NREQ-1:0]          o_rsp_valid;
  logic [NREQ-1:0][DW-1:0]  o_rsp_rdata;

  logic [AW-1:0]            o_sram_addr_a;
  logic [AW-1:0]            o_sram_addr_b;
  logic [DW-1:0]            o_sram_wdata_a;
  logic [DW-1:0]            o_sram_wdata_b;
  logic [BW-1:0]            o_sram_bmask_a;
  logic [BW-1:0]            o_sram_bmask_b;
  logic                     o_sram_wren_a;
  logic                     o_sram_wren_b;
  logic [DW-1:0]            i_sram_rdata_a;
  logic [DW-1:0]            i_sram_rdata_b;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_wren, i_req_wdata, i_req_bmask,
    input  i_sram_rdata_a, i_sram_rdata_b,
    output o_req_ready, o_rsp_valid, o_rsp_rdata,
    output o_sram_addr_a, o_sram_addr_b, o_sram_wdata_a, o_sram_wdata_b,
    output o_sram_bmask_a, o_sram_bmask_b, o_sram_wren_a, o_sram_wren_b
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_wren, i_req_wdata, i_req_bmask,
    output i_sram_rdata_a, i_sram_rdata_b,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata,
    input  o_sram_addr_a, o_sram_addr_b, o_sram_wdata_a, o_sram_wdata_b,
    input  o_sram_bmask_a, o_sram_bmask_b, o_sram_wren_a, o_sram_wren_b
  );

endinterface

// File: rtl/rr_arbiter.sv
// N-slot one-hot arbiter for port B. Round-robin when SRAM_ARB_RR_EN is
// defined, otherwise fixed priority (slot 0 highest) with no pointer state.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned XW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [XW-1:0] index
);

`ifdef SRAM_ARB_RR_EN
  logic [XW-1:0] rr_ptr;

  // Pointer moves to the winner only when the grant is actually taken.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      rr_ptr <= XW'(rr_ptr_rst(N));
    else if (advance) rr_ptr <= index;
  end

  // Search starts one past the pointer and wraps.
  always_comb begin
    logic [XW:0] j;
    grant = '0;
    index = '0;
    j     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = {1'b0, rr_ptr} + (XW+1)'(k);
      if (j >= (XW+1)'(N)) j = j - (XW+1)'(N);
      if (grant == '0 && req[j[XW-1:0]]) begin
        grant[j[XW-1:0]] = 1'b1;
        index            = j[XW-1:0];
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, i_clk, i_reset, advance};

  // Lowest slot wins.
  always_comb begin
    grant = '0;
    index = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant == '0 && req[XW'(k)]) begin
        grant[XW'(k)] = 1'b1;
        index         = XW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Dual-port data SRAM arbiter: port A dedicated to requester 0, port B shared
// by requesters 1..NREQ-1, one-cycle read responses routed to the issuer.
// Build option: SRAM_ARB_RR_EN selects round-robin (else fixed priority) on port B.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned AW   = AW_DEF,
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IW   = $clog2(NREQ),
  localparam int unsigned NB   = NREQ - 1,
  localparam int unsigned XW   = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  sram_port_arbiter_if.slave  bus
);

  sram_req_t       req [NREQ];
  sram_rsp_t       rsp [NREQ];
  logic [NB-1:0]   b_grant;
  logic [XW-1:0]   b_idx;
  logic [IW-1:0]   b_win;
  logic            acc_a;
  logic            acc_b;
  logic            collide;
  logic            pend_a;
  logic            pend_b;
  logic [IW-1:0]   own_b;

  // Unpack requester bus into request structs.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req[i].addr  = AW_DEF'(bus.i_req_addr[IW'(i)]);
      req[i].wren  = bus.i_req_wren[IW'(i)];
      req[i].wdata = bus.i_req_wdata[IW'(i)];
      req[i].bmask = bus.i_req_bmask[IW'(i)];
    end
  end

  rr_arbiter #(.N(NB)) u_rr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .req     (bus.i_req_valid[NREQ-1:1]),
    .advance (acc_b),
    .grant   (b_grant),
    .index   (b_idx)
  );

  assign b_win = IW'(b_idx) + IW'(1);

  // Grants, port-A write vs port-B same-address collision, SRAM pin muxing.
  always_comb begin
    bus.o_req_ready    = '0;
    bus.o_sram_addr_a  = '0;
    bus.o_sram_wdata_a = '0;
    bus.o_sram_bmask_a = '0;
    bus.o_sram_wren_a  = 1'b0;
    bus.o_sram_addr_b  = '0;
    bus.o_sram_wdata_b = '0;
    bus.o_sram_bmask_b = '0;
    bus.o_sram_wren_b  = 1'b0;

    acc_a   = bus.i_req_valid[0] && !i_reset;
    collide = acc_a && req[0].wren && (|b_grant) && (req[b_win].addr == req[0].addr);
    acc_b   = (|b_grant) && !collide && !i_reset;

    if (acc_a) begin
      bus.o_req_ready[0] = 1'b1;
      bus.o_sram_addr_a  = AW'(req[0].addr);
      bus.o_sram_wdata_a = req[0].wdata;
      bus.o_sram_bmask_a = req[0].bmask;
      bus.o_sram_wren_a  = req[0].wren;
    end
    if (acc_b) begin
      bus.o_req_ready[b_win] = 1'b1;
      bus.o_sram_addr_b      = AW'(req[b_win].addr);
      bus.o_sram_wdata_b     = req[b_win].wdata;
      bus.o_sram_bmask_b     = req[b_win].bmask;
      bus.o_sram_wren_b      = req[b_win].wren;
    end
  end

  // Track which requester owns each port's read data next cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      own_b  <= '0;
    end else begin
      pend_a <= acc_a && !req[0].wren;
      pend_b <= acc_b && !req[b_win].wren;
      if (acc_b && !req[b_win].wren) own_b <= b_win;
    end
  end

  // Route returned read data to its owner; zero elsewhere.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp[i] = '0;
      if (i == 0 && pend_a) begin
        rsp[i].valid = 1'b1;
        rsp[i].rdata = bus.i_sram_rdata_a;
      end else if (i != 0 && pend_b && own_b == IW'(i)) begin
        rsp[i].valid = 1'b1;
        rsp[i].rdata = bus.i_sram_rdata_b;
      end
      bus.o_rsp_valid[IW'(i)] = rsp[i].valid;
      bus.o_rsp_rdata[IW'(i)] = rsp[i].rdata;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic,
// compared against a transaction-level model of grants and memory contents.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned AW    = 14;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

  sram_port_arbiter #(.AW(AW), .NREQ(NREQ)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int unsigned a);
    return (32'(a) * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural SRAM macro: registered read of the pre-write word, masked write.
  bit [31:0] sram    [DEPTH];
  bit        written [DEPTH];

  function automatic logic [31:0] sram_rd(input logic [AW-1:0] a);
    return written[a] ? sram[a] : init_word(32'(a));
  endfunction

  always @(posedge clk) begin
    bus.i_sram_rdata_a <= sram_rd(bus.o_sram_addr_a);
    bus.i_sram_rdata_b <= sram_rd(bus.o_sram_addr_b);
    if (bus.o_sram_wren_a) begin
      sram[bus.o_sram_addr_a]    <= merge(sram_rd(bus.o_sram_addr_a), bus.o_sram_wdata_a, bus.o_sram_bmask_a);
      written[bus.o_sram_addr_a] <= 1'b1;
    end
    if (bus.o_sram_wren_b) begin
      sram[bus.o_sram_addr_b]    <= merge(sram_rd(bus.o_sram_addr_b), bus.o_sram_wdata_b, bus.o_sram_bmask_b);
      written[bus.o_sram_addr_b] <= 1'b1;
    end
  end

  // Reference model state.
  bit [31:0]   ref_mem [int unsigned];
  int unsigned last_b = NREQ - 1;
  bit          exp_v [NREQ];
  logic [31:0] exp_d [NREQ];

  function automatic logic [31:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Pending request held by each requester until accepted.
  bit          pv [NREQ];
  logic [AW-1:0] pa [NREQ];
  bit          pw [NREQ];
  logic [31:0] pd [NREQ];
  logic [3:0]  pm [NREQ];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input bit w, input int unsigned a,
                         input logic [31:0] d, input logic [3:0] m);
    pv[i] = 1'b1; pw[i] = w; pa[i] = AW'(a); pd[i] = d; pm[i] = m;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.i_req_valid[i] = pv[i];
      bus.i_req_addr[i]  = pa[i];
      bus.i_req_wren[i]  = pw[i];
      bus.i_req_wdata[i] = pd[i];
      bus.i_req_bmask[i] = pm[i];
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step();
    bit              acc [NREQ];
    int              win;
    int unsigned     c;
    logic [NREQ-1:0] exp_rdy;
    drive();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      check($sformatf("rsp_valid[%0d]", i), 32'(bus.o_rsp_valid[i]), 32'(exp_v[i]));
      check($sformatf("rsp_rdata[%0d]", i), bus.o_rsp_rdata[i], exp_v[i] ? exp_d[i] : 32'h0);
    end
    win = -1;
    if (!rst) begin
      for (int unsigned k = 1; k < NREQ; k++) begin
`ifdef SRAM_ARB_RR_EN
        c = last_b + k;
        if (c > NREQ - 1) c = c - (NREQ - 1);
`else
        c = k;
`endif
        if (win < 0 && pv[c]) win = int'(c);
      end
      if (win >= 0 && pv[0] && pw[0] && pa[win] == pa[0]) win = -1;
    end
    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
    acc[0] = pv[0] && !rst;
    if (win >= 0) acc[win] = 1'b1;
    for (int i = 0; i < NREQ; i++) exp_rdy[i] = acc[i];
    check("req_ready", 32'(bus.o_req_ready), 32'(exp_rdy));
    check("sram_a_ctl", 32'({bus.o_sram_wren_a, bus.o_sram_bmask_a, bus.o_sram_addr_a}),
          acc[0] ? 32'({pw[0], pm[0], pa[0]}) : 32'h0);
    check("sram_a_wdata", bus.o_sram_wdata_a, acc[0] ? pd[0] : 32'h0);
    check("sram_b_ctl", 32'({bus.o_sram_wren_b, bus.o_sram_bmask_b, bus.o_sram_addr_b}),
          (win >= 0) ? 32'({pw[win], pm[win], pa[win]}) : 32'h0);
    check("sram_b_wdata", bus.o_sram_wdata_b, (win >= 0) ? pd[win] : 32'h0);
    for (int i = 0; i < NREQ; i++) begin
      exp_v[i] = acc[i] && !pw[i];
      exp_d[i] = exp_v[i] ? ref_rd(32'(pa[i])) : 32'h0;
    end
    for (int i = 0; i < NREQ; i++)
      if (acc[i] && pw[i]) ref_mem[32'(pa[i])] = merge(ref_rd(32'(pa[i])), pd[i], pm[i]);
    if (win >= 0) last_b = win;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) pv[i] = 1'b0;
  endtask

  task automatic model_reset();
    last_b = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = 32'h0;
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 32'h0, 4'h0);
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    drive();
    #1 rst = 1'b1;
    model_reset();

    // Reset: requests present but nothing granted, no responses.
    set_req(0, 1'b0, 32'h3, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h4, 32'h0, 4'hF);
    step();
    rst = 1'b0;
    step();
    step();

    // Read after write on port A.
    set_req(0, 1'b1, 32'h0010, 32'hDEAD_BEEF, 4'hF); step();
    set_req(0, 1'b0, 32'h0010, 32'h0, 4'h0);         step();
    step();

    // Byte mask merge.
    set_req(0, 1'b1, 32'h0040, 32'hAABB_CCDD, 4'hF); step();
    set_req(0, 1'b1, 32'h0040, 32'h1122_3344, 4'h5); step();
    set_req(0, 1'b0, 32'h0040, 32'h0, 4'h0);         step();
    step();

    // Both port-B requesters reading continuously.
    for (int n = 0; n < 6; n++) begin
      if (!pv[1]) set_req(1, 1'b0, 32'h100 + n, 32'h0, 4'h0);
      if (!pv[2]) set_req(2, 1'b0, 32'h200 + n, 32'h0, 4'h0);
      step();
    end
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    step();

    // Same-address write collision, then readback.
    set_req(0, 1'b1, 32'h020, 32'h0A0A_0A0A, 4'hF);
    set_req(1, 1'b1, 32'h020, 32'hB1B1_B1B1, 4'hF);
    step(); step();
    set_req(0, 1'b0, 32'h020, 32'h0, 4'h0); step(); step();

    // Concurrent reads on both ports.
    set_req(0, 1'b0, 32'h030, 32'h0, 4'h0);
    set_req(2, 1'b0, 32'h031, 32'h0, 4'h0);
    step(); step();

    // Reset with a port-B read in flight: response dropped.
    set_req(1, 1'b0, 32'h005, 32'h0, 4'h0); step();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    set_req(1, 1'b0, 32'h005, 32'h0, 4'h0); step(); step();

    // Random traffic over a small address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pv[i] && $urandom_range(0, 3) != 0)
          set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  $urandom, 4'($urandom_range(0, 15)));
      step();
    end
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
